// File: rtl/mem_seq_pkg.sv
// Shared constants and the FSM state type for the memory access sequencer.
package mem_seq_pkg;

  localparam logic [1:0] PTR_X  = 2'd0;
  localparam logic [1:0] PTR_Y  = 2'd1;
  localparam logic [1:0] PTR_Z  = 2'd2;
  localparam logic [1:0] PTR_SP = 2'd3;

  localparam logic [1:0] MODE_PLAIN   = 2'd0;
  localparam logic [1:0] MODE_POSTINC = 2'd1;
  localparam logic [1:0] MODE_PREDEC  = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRE_ADJ  = 3'd1,
    ACCESS   = 3'd2,
    POST_ADJ = 3'd3,
    DONE     = 3'd4
  } state_e;

  function automatic logic [3:0] ptr_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request, memory-port, pointer write-back and response signals of the sequencer.
interface mem_access_sequencer_if;
  // A request transfers on any clock edge where req_valid and req_ready are both 1;
  // the requester holds every req_* field stable while req_valid is 1 and ready is 0.
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_ptr;
  logic [1:0]  req_mode;
  logic        req_write;
  logic        req_word;
  logic [15:0] req_wdata;
  logic [3:0]  sel_signals;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [3:0]  ptr_wr_en;
  logic [15:0] ptr_wr_data;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] resp_rdata;

  modport master (
    output req_valid, req_ptr, req_mode, req_write, req_word, req_wdata,
    output mem_addr, mem_rdata, mem_ack,
    input  req_ready, sel_signals, mem_req, mem_we, mem_wdata,
    input  ptr_wr_en, ptr_wr_data, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_ptr, req_mode, req_write, req_word, req_wdata,
    input  mem_addr, mem_rdata, mem_ack,
    output req_ready, sel_signals, mem_req, mem_we, mem_wdata,
    output ptr_wr_en, ptr_wr_data, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/mem_seq_ptr_adj.sv
// Pointer +/-1 adder; wraps modulo 2^16 with no carry or borrow flag.
module mem_seq_ptr_adj (
  input  logic [15:0] ptr_i,
  input  logic        dec_i,
  output logic [15:0] ptr_o
);
  assign ptr_o = dec_i ? (ptr_i - 16'd1) : (ptr_i + 16'd1);
endmodule

// File: rtl/mem_access_sequencer.sv
// Pointer-based load/store sequencer with plain, post-increment and pre-decrement modes.
// Define MEM_SEQ_WORD_EN to enable two-beat word accesses; otherwise req_word is ignored.
module mem_access_sequencer
  import mem_seq_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset_n,
  mem_access_sequencer_if.slave        bus,
  output state_e                       dbg_state_o
);

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  mode_q, mode_d;
  logic        write_q, write_d;
  logic        word_q, word_d;
  logic        err_q, err_d;
  logic        beat_q, beat_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rdy_q;

  logic        req_word_eff;
  logic        illegal;
  logic        last_beat;
  logic        hi_byte;
  logic [15:0] adj_ptr;

`ifdef MEM_SEQ_WORD_EN
  assign req_word_eff = bus.req_word;
`else
  logic unused_req_word;
  assign unused_req_word = bus.req_word;
  assign req_word_eff    = 1'b0;
`endif

  assign illegal = (bus.req_mode == MODE_ILLEGAL) ||
                   (req_word_eff && (bus.req_mode == MODE_PLAIN));

  // beat_q marks the second beat; pre-dec walks downward so its first beat is the high byte.
  assign last_beat = !word_q || beat_q;
  assign hi_byte   = word_q && ((mode_q == MODE_PREDEC) ? !beat_q : beat_q);

  mem_seq_ptr_adj u_ptr_adj (
    .ptr_i (bus.mem_addr),
    .dec_i (state_q == PRE_ADJ),
    .ptr_o (adj_ptr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      mode_q  <= 2'd0;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= 1'b0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      write_q <= write_d;
      word_q  <= word_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    write_d = write_q;
    word_d  = word_q;
    err_d   = err_q;
    beat_d  = beat_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    bus.req_ready   = 1'b0;
    bus.sel_signals = 4'b0000;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_wdata   = 8'h00;
    bus.ptr_wr_en   = 4'b0000;
    bus.ptr_wr_data = 16'h0000;
    bus.resp_valid  = 1'b0;
    bus.resp_err    = 1'b0;

    case (state_q)
      IDLE: begin
        // Held low for the first cycle out of reset.
        bus.req_ready = rdy_q;
        if (bus.req_valid && rdy_q) begin
          ptr_d   = bus.req_ptr;
          mode_d  = bus.req_mode;
          write_d = bus.req_write;
          word_d  = req_word_eff;
          wdata_d = bus.req_wdata;
          err_d   = illegal;
          beat_d  = 1'b0;
          rdata_d = 16'h0000;
          if (illegal)                         state_d = DONE;
          else if (bus.req_mode == MODE_PREDEC) state_d = PRE_ADJ;
          else                                 state_d = ACCESS;
        end
      end
      PRE_ADJ: begin
        bus.sel_signals = ptr_onehot(ptr_q);
        bus.ptr_wr_en   = ptr_onehot(ptr_q);
        bus.ptr_wr_data = adj_ptr;
        state_d         = ACCESS;
      end
      ACCESS: begin
        bus.sel_signals = ptr_onehot(ptr_q);
        bus.mem_req     = 1'b1;
        bus.mem_we      = write_q;
        if (write_q) bus.mem_wdata = hi_byte ? wdata_q[15:8] : wdata_q[7:0];
        if (bus.mem_ack) begin
          if (!write_q) begin
            if (hi_byte) rdata_d[15:8] = bus.mem_rdata;
            else         rdata_d[7:0]  = bus.mem_rdata;
          end
          if (mode_q == MODE_POSTINC) begin
            state_d = POST_ADJ;
          end else if ((mode_q == MODE_PREDEC) && !last_beat) begin
            beat_d  = 1'b1;
            state_d = PRE_ADJ;
          end else begin
            state_d = DONE;
          end
        end
      end
      POST_ADJ: begin
        bus.sel_signals = ptr_onehot(ptr_q);
        bus.ptr_wr_en   = ptr_onehot(ptr_q);
        bus.ptr_wr_data = adj_ptr;
        if (!last_beat) begin
          beat_d  = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench: pointer file, byte memory and ack delay modelled here;
// each request is predicted from the addressing rules and compared against the observed trace.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

`ifdef MEM_SEQ_WORD_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  mem_access_sequencer_if bus();
  state_e dbg_state;

  mem_access_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- environment: pointer file, memory, ack timing ----------------
  logic [7:0]  mem_arr [0:65535];
  logic [15:0] ptr_r [4];
  int          ack_dly;
  int          wait_cnt;

  assign bus.mem_addr  = bus.sel_signals[0] ? ptr_r[0] :
                         bus.sel_signals[1] ? ptr_r[1] :
                         bus.sel_signals[2] ? ptr_r[2] :
                         bus.sel_signals[3] ? ptr_r[3] : 16'h0000;
  assign bus.mem_rdata = mem_arr[bus.mem_addr];
  assign bus.mem_ack   = bus.mem_req && (wait_cnt == ack_dly);

  // ---------------- scoreboard state ----------------
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  int          acc_cyc_q[$];
  int          resp_cyc_q[$];
  int          vectors;
  int          miscompares;
  int          cyc;
  int          mreq_cnt, pw_cnt, sel_bad, ovl_bad;
  logic        resp_err_s;
  logic [15:0] resp_rdata_s;
  logic [3:0]  cur_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample at negedge, then apply memory / pointer side effects just after posedge.
  task automatic step();
    logic [3:0]  pwe;
    logic [15:0] pwd;
    logic        mreq, mack, mwe;
    logic [7:0]  mwd;
    logic [15:0] maddr;
    @(negedge clock);
    pwe   = bus.ptr_wr_en;
    pwd   = bus.ptr_wr_data;
    mreq  = bus.mem_req;
    mack  = bus.mem_ack;
    mwe   = bus.mem_we;
    mwd   = bus.mem_wdata;
    maddr = bus.mem_addr;
    if (bus.req_valid && bus.req_ready) acc_cyc_q.push_back(cyc);
    if (mreq) mreq_cnt++;
    if (mreq && mack) obs_q.push_back({mwe, maddr, mwe ? mwd : 8'h00});
    if (bus.resp_valid) begin
      resp_cyc_q.push_back(cyc);
      resp_err_s   = bus.resp_err;
      resp_rdata_s = bus.resp_rdata;
    end
    if (pwe != 4'b0000) pw_cnt++;
    if ((bus.sel_signals != 4'b0000 || mreq || pwe != 4'b0000) && bus.sel_signals != cur_sel) sel_bad++;
    if (bus.resp_valid && bus.sel_signals != 4'b0000) sel_bad++;
    if (bus.req_ready && (mreq || bus.resp_valid || pwe != 4'b0000)) ovl_bad++;
    @(posedge clock);
    #1;
    cyc++;
    if (mreq && mack && mwe) mem_arr[maddr] = mwd;
    for (int i = 0; i < 4; i++) if (pwe[i]) ptr_r[i] = pwd;
    if (mreq && !mack) wait_cnt++;
    else               wait_cnt = 0;
  endtask

  task automatic clear_trace();
    exp_q.delete();
    obs_q.delete();
    acc_cyc_q.delete();
    resp_cyc_q.delete();
    mreq_cnt     = 0;
    pw_cnt       = 0;
    sel_bad      = 0;
    ovl_bad      = 0;
    resp_err_s   = 1'bx;
    resp_rdata_s = 16'hxxxx;
  endtask

  // Predict a request from the addressing rules, drive it, and compare the whole trace.
  task automatic run_txn(input string tag, input logic [1:0] p, input logic [1:0] md,
                         input logic wr, input logic wd, input logic [15:0] wdata,
                         input logic [15:0] pval, input int dly);
    logic        word_eff, illegal;
    int          n, budget, exp_lat, lat;
    logic [15:0] base, addr, exp_rdata;
    logic [15:0] exp_ptr [4];
    clear_trace();
    ptr_r[p] = pval;
    ack_dly  = dly;
    cur_sel  = 4'b0001 << p;
    for (int i = 0; i < 4; i++) exp_ptr[i] = ptr_r[i];
    word_eff  = WORD_EN && wd;
    illegal   = (md == 2'd3) || (word_eff && md == 2'd0);
    n         = word_eff ? 2 : 1;
    exp_rdata = 16'h0000;
    exp_lat   = 1;
    if (!illegal) begin
      // Lowest address of the access holds the low byte, whatever the beat order.
      base = (md == 2'd2) ? pval - 16'(n) : pval;
      for (int b = 0; b < n; b++) begin
        addr = (md == 2'd2) ? pval - 16'(b + 1) : pval + 16'(b);
        exp_q.push_back({wr, addr, wr ? ((addr == base) ? wdata[7:0] : wdata[15:8]) : 8'h00});
      end
      exp_rdata = {(n == 2) ? mem_arr[base + 16'd1] : 8'h00, mem_arr[base]};
      if (md == 2'd1)      exp_ptr[p] = pval + 16'(n);
      else if (md == 2'd2) exp_ptr[p] = pval - 16'(n);
      exp_lat = n * (dly + 1) + ((md == 2'd0) ? 0 : n) + 1;
    end

    bus.req_ptr   = p;
    bus.req_mode  = md;
    bus.req_write = wr;
    bus.req_word  = wd;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    budget = 0;
    while (acc_cyc_q.size() == 0 && budget < 50) begin step(); budget++; end
    bus.req_valid = 1'b0;
    while (resp_cyc_q.size() == 0 && budget < 200) begin step(); budget++; end
    step();
    step();

    lat = (acc_cyc_q.size() > 0 && resp_cyc_q.size() > 0) ? resp_cyc_q[0] - acc_cyc_q[0] : -1;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_resp_pulses"}, 32'(resp_cyc_q.size()), 32'd1);
    check({tag, "_resp_err"}, {31'd0, resp_err_s}, {31'd0, illegal});
    if (!wr && !illegal) check({tag, "_rdata"}, {16'd0, resp_rdata_s}, {16'd0, exp_rdata});
    check({tag, "_mem_req_cycles"}, 32'(mreq_cnt), illegal ? 32'd0 : 32'(n * (dly + 1)));
    check({tag, "_ptr_writes"}, 32'(pw_cnt), (illegal || md == 2'd0) ? 32'd0 : 32'(n));
    check({tag, "_beats"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i),
            (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_ptr%0d", tag, i), {16'd0, ptr_r[i]}, {16'd0, exp_ptr[i]});
    check({tag, "_sel_ready_rules"}, 32'(sel_bad + ovl_bad), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0]  rp, rm;
    logic        rw, rwd;
    logic [15:0] rwdata, rpv;
    int          rdly, budget, gap;

    vectors = 0; miscompares = 0; cyc = 0;
    ack_dly = 0; wait_cnt = 0; cur_sel = 4'b0000;
    bus.req_valid = 1'b0; bus.req_ptr = 2'd0; bus.req_mode = 2'd0;
    bus.req_write = 1'b0; bus.req_word = 1'b0; bus.req_wdata = 16'h0000;
    for (int i = 0; i < 4; i++) ptr_r[i] = 16'h0000;
    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'($urandom);
    clear_trace();

    // Reset: everything low, ready rises one clock after release.
    #1 reset_n = 1'b0;
    #1;
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_outputs", {bus.mem_req, bus.mem_we, bus.resp_valid, bus.resp_err,
                          bus.sel_signals, bus.ptr_wr_en}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clock);
    #1;
    check("rst_ready_after_edge", {31'd0, bus.req_ready}, 32'd1);

    // Byte load Y plain.
    mem_arr[16'h1234] = 8'h5A;
    run_txn("y_plain_ld", PTR_Y, MODE_PLAIN, 1'b0, 1'b0, 16'h0000, 16'h1234, 0);
    check("y_plain_ld_value", {16'd0, resp_rdata_s}, 32'h0000_005A);

    run_txn("sp_predec_word_st", PTR_SP, MODE_PREDEC, 1'b1, 1'b1, 16'hBEEF, 16'h0100, 0);
    run_txn("x_postinc_wrap_ld", PTR_X, MODE_POSTINC, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 3);
    check("x_postinc_wrap_ptr", {16'd0, ptr_r[PTR_X]}, 32'h0000_0000);
    run_txn("z_predec_wrap_st", PTR_Z, MODE_PREDEC, 1'b1, 1'b0, 16'h1234, 16'h0000, 1);
    run_txn("z_postinc_word_ld", PTR_Z, MODE_POSTINC, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 0);
    run_txn("sp_predec_word_ld", PTR_SP, MODE_PREDEC, 1'b0, 1'b1, 16'h0000, 16'h0000, 2);
    run_txn("illegal_mode3", PTR_X, MODE_ILLEGAL, 1'b1, 1'b0, 16'hA5A5, 16'h4000, 0);
    run_txn("word_plain", PTR_Y, MODE_PLAIN, 1'b1, 1'b1, 16'h5AA5, 16'h3000, 0);

    // Reset while waiting for ack.
    clear_trace();
    ptr_r[PTR_Z] = 16'h0800;
    cur_sel      = 4'b0100;
    ack_dly      = 10;
    bus.req_ptr = PTR_Z; bus.req_mode = MODE_POSTINC; bus.req_write = 1'b0;
    bus.req_word = 1'b0; bus.req_valid = 1'b1;
    budget = 0;
    while (acc_cyc_q.size() == 0 && budget < 20) begin step(); budget++; end
    bus.req_valid = 1'b0;
    while (mreq_cnt == 0 && budget < 40) begin step(); budget++; end
    check("midrst_mem_req_before", {31'd0, bus.mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_mem_req_dropped", {31'd0, bus.mem_req}, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    wait_cnt = 0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    resp_cyc_q.delete();
    pw_cnt = 0;
    repeat (6) step();
    check("midrst_no_resp", 32'(resp_cyc_q.size()), 32'd0);
    check("midrst_no_ptr_wr", 32'(pw_cnt), 32'd0);
    check("midrst_ptr_kept", {16'd0, ptr_r[PTR_Z]}, 32'h0000_0800);

    // Back-to-back with req_valid held across both requests.
    clear_trace();
    ptr_r[PTR_Y] = 16'h2000;
    cur_sel      = 4'b0010;
    ack_dly      = 0;
    bus.req_ptr = PTR_Y; bus.req_mode = MODE_PLAIN; bus.req_write = 1'b0;
    bus.req_word = 1'b0; bus.req_valid = 1'b1;
    budget = 0;
    while (acc_cyc_q.size() < 2 && budget < 60) begin step(); budget++; end
    bus.req_valid = 1'b0;
    while (resp_cyc_q.size() < 2 && budget < 120) begin step(); budget++; end
    gap = (acc_cyc_q.size() >= 2 && resp_cyc_q.size() >= 1) ? acc_cyc_q[1] - resp_cyc_q[0] : -1;
    check("b2b_second_accept_gap", 32'(gap), 32'd1);
    check("b2b_resp_count", 32'(resp_cyc_q.size()), 32'd2);
    check("b2b_overlap", 32'(ovl_bad + sel_bad), 32'd0);

    // Randomized requests, including wrap-prone pointer values.
    for (int k = 0; k < 24; k++) begin
      rp     = 2'($urandom_range(0, 3));
      rm     = 2'($urandom_range(0, 3));
      rw     = 1'($urandom_range(0, 1));
      rwd    = 1'($urandom_range(0, 1));
      rwdata = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rpv = 16'hFFFF;
        1:       rpv = 16'h0000;
        2:       rpv = 16'h0001;
        default: rpv = 16'($urandom);
      endcase
      rdly = $urandom_range(0, 2);
      run_txn($sformatf("rnd%0d", k), rp, rm, rw, rwd, rwdata, rpv, rdly);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 The block SHALL be clocked by a single clock and reset by an asynchronous active-low reset, with ports named clock and reset_n.
REQ-002 Ports SHALL be:
 clock        in   1   rising-edge clock
 reset_n      in   1   async active-low reset
 req_valid    in   1   access request present
 req_ready    out  1   sequencer idle, request accepted when valid&ready
 req_ptr      in   2   pointer: 0 X, 1 Y, 2 Z, 3 SP
 req_mode     in   2   0 plain, 1 post-inc, 2 pre-dec, 3 illegal
 req_write    in   1   1 store, 0 load
 req_word     in   1   1 two-byte access, 0 byte
 req_wdata    in   16  store data (low byte at lower address)
 sel_signals  out  4   one-hot select to mem_addr_sel_mux (bit0 X .. bit3 SP)
 mem_addr     in   16  selected pointer returned from mem_addr_sel_mux
 mem_req      out  1   memory byte-access strobe
 mem_we       out  1   write enable, valid with mem_req
 mem_wdata    out  8   write byte
 mem_rdata    in   8   read byte, valid with mem_ack
 mem_ack      in   1   access complete (same cycle or later)
 ptr_wr_en    out  4   one-hot pointer write-back strobe
 ptr_wr_data  out  16  new pointer value
 resp_valid   out  1   one-cycle completion pulse
 resp_err     out  1   illegal request, valid with resp_valid
 resp_rdata   out  16  load result, valid with resp_valid

Function
REQ-003 FSM states SHALL be IDLE, PRE_ADJ, ACCESS, POST_ADJ, DONE.
REQ-004 IDLE: req_ready=1; on valid&ready latch all req_* fields; go PRE_ADJ if mode=pre-dec, else ACCESS; illegal request goes directly to DONE.
REQ-005 Illegal request SHALL be mode=3, or req_word=1 with mode=plain; it SHALL produce resp_err=1 with no mem_req and no ptr_wr_en.
REQ-006 sel_signals SHALL be one-hot of the latched pointer in PRE_ADJ/ACCESS/POST_ADJ and 4'b0000 in IDLE/DONE.
REQ-007 PRE_ADJ: one cycle, ptr_wr_en one-hot, ptr_wr_data=mem_addr-1 mod 2^16; next ACCESS.
REQ-008 ACCESS: mem_req=1, mem_we=req_write, held until mem_ack; no other outputs change while waiting.
REQ-009 On mem_ack: post-inc -> POST_ADJ; pre-dec with beat remaining -> PRE_ADJ; otherwise -> DONE.
REQ-010 POST_ADJ: one cycle, ptr_wr_data=mem_addr+1 mod 2^16; next ACCESS if beat remains, else DONE.
REQ-011 Word beat order: post-inc low byte then high byte; pre-dec high byte then low byte; mem_wdata selects matching byte of req_wdata and mem_rdata fills matching byte of resp_rdata.
REQ-012 Byte load SHALL zero-extend into resp_rdata[15:8].
REQ-013 DONE: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in all non-IDLE states.
REQ-014 Latency (mem_ack same cycle): plain byte resp_valid 2 cycles after accept; post-inc byte 3; pre-dec byte 3; word post-inc/pre-dec 5.
REQ-015 Pointer wrap SHALL be modulo 2^16 (0x0000-1=0xFFFF, 0xFFFF+1=0x0000), no flag.

Reset
REQ-016 reset_n low SHALL asynchronously force IDLE and drive all outputs 0 except req_ready, which SHALL be 1 one cycle after reset_n deasserts.
REQ-017 Reset mid-access SHALL drop mem_req immediately and issue no further ptr_wr_en or resp_valid.

Configuration
REQ-018 With MEM_SEQ_WORD_EN defined, two-beat word accesses SHALL be supported per REQ-011; without it, req_word SHALL be ignored and all accesses are single byte.

Structure
REQ-019 Package mem_seq_pkg SHALL hold pointer index constants, mode encodings and the FSM state enum.
REQ-020 The ±1 wrap adder SHALL be sub-module mem_seq_ptr_adj (16-bit input, direction input, 16-bit output).

Verification
REQ-021 Byte load Y plain, Y=0x1234, rdata=0x5A, ack same cycle -> mem_req 1 cycle, sel=0010, resp_rdata=0x005A 2 cycles after accept, no ptr_wr_en.
REQ-022 Word store SP pre-dec, SP=0x0100, wdata=0xBEEF -> writes 0xBE at 0x00FF, 0xEF at 0x00FE, SP=0x00FE, resp at cycle 5.
REQ-023 Byte load X post-inc, X=0xFFFF, ack delayed 3 cycles -> mem_req held 4 cycles, ptr_wr_data=0x0000.
REQ-024 mode=3 or word+plain -> resp_valid and resp_err=1 one cycle after accept, no mem_req, no ptr_wr_en.
REQ-025 reset_n low while mem_req=1 awaiting ack -> mem_req=0 same cycle, state IDLE, no resp_valid.
REQ-026 Back-to-back requests with req_valid held -> second accepted only in the cycle after DONE; no overlap of mem_req.
